// File: rtl/reg_bank_wb_pkg.sv
// rtl/reg_bank_wb_pkg.sv - shared CPU constants and register index type
package reg_bank_wb_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t    REG_ZERO     = 5'd0;
  localparam reg_idx_t    REG_SP       = 5'd29;
  // Also the selector-0 word of the memory-to-register mux; keep them identical.
  localparam logic [31:0] SP_RESET_VAL = 32'h000000E3;

endpackage

// File: rtl/reg_bank_wb_wr_decoder.sv
// rtl/reg_bank_wb_wr_decoder.sv - one-hot write-enable decoder for the register bank
module reg_wr_decoder
  import reg_bank_wb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  output logic [NREGS-1:0]  wr_en
);

  always_comb begin
    wr_en = '0;
    if (reg_write && (write_reg != ADDR_W'(REG_ZERO))) begin
      wr_en[write_reg] = 1'b1;
    end
    wr_en[0] = 1'b0;
  end

endmodule

// File: rtl/reg_bank_wb.sv
// rtl/reg_bank_wb.sv - 32x32 write-back register bank with registered dual read ports
// Optional same-edge write-to-read forwarding: REG_BANK_BYPASS_EN
module reg_bank_wb
  import reg_bank_wb_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 SP_IDX   = int'(REG_SP),
  parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(SP_RESET_VAL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [15:0]       wb_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [NREGS-1:0]  wr_en;

  reg_wr_decoder #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_dec (
    .reg_write (reg_write),
    .write_reg (write_reg),
    .wr_en     (wr_en)
  );

  // wr_en[0] is never set, so index 0 is never forwarded.
  always_comb begin
    rd1_d = (read_reg_1 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[read_reg_1];
    rd2_d = (read_reg_2 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[read_reg_2];
`ifdef REG_BANK_BYPASS_EN
    if (wr_en[read_reg_1]) rd1_d = write_data;
    if (wr_en[read_reg_2]) rd2_d = write_data;
`else
`endif
    cnt_d = cnt_q + 16'(|wr_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      rd1_q <= '0;
      rd2_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) regs_q[i] <= write_data;
      end
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      cnt_q <= cnt_d;
    end
  end

  assign read_data_1 = rd1_q;
  assign read_data_2 = rd2_q;
  assign wb_count    = cnt_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// tb/tb_reg_bank_wb.sv - randomized self-checking bench for reg_bank_wb
module tb_reg_bank_wb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg_1 = '0;
  logic [4:0]  read_reg_2 = '0;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [15:0] wb_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_reg [32];
  logic [31:0] m_rd1, m_rd2;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  reg_bank_wb dut (
    .clk         (clk),
    .reset       (reset),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .wb_count    (wb_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd1", read_data_1, m_rd1);
      chk("model_rd2", read_data_2, m_rd2);
      chk("model_cnt", {16'h0, wb_count}, {16'h0, m_cnt});
    end
  end

  // One clock: drive inputs, then advance the model by the rules of one edge.
  task automatic cyc(input logic rst, input logic we, input logic [4:0] wr,
                     input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    logic acc;
    reset = rst; reg_write = we; write_reg = wr; write_data = wd;
    read_reg_1 = r1; read_reg_2 = r2;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_reg[29] = 32'h000000E3;
      m_rd1 = 32'h0; m_rd2 = 32'h0; m_cnt = 16'h0;
    end else begin
      acc = we && (wr != 5'd0);
      m_rd1 = (r1 == 5'd0) ? 32'h0 : m_reg[r1];
      m_rd2 = (r2 == 5'd0) ? 32'h0 : m_reg[r2];
`ifdef REG_BANK_BYPASS_EN
      if (acc && wr == r1) m_rd1 = wd;
      if (acc && wr == r2) m_rd2 = wd;
`endif
      if (acc) begin
        m_reg[wr] = wd;
        m_cnt = m_cnt + 16'd1;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] exp_byp;
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk_en = 1'b1;

    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
    chk("reset_sp_read", read_data_1, 32'h000000E3);
    chk("reset_r5_read", read_data_2, 32'h0);
    chk("reset_count", {16'h0, wb_count}, 32'h0);

    cyc(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
    chk("write8_read", read_data_1, 32'hDEADBEEF);
    chk("write8_count", {16'h0, wb_count}, 32'd1);

    cyc(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd1, 5'd1);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("write0_read", read_data_1, 32'h0);
    chk("write0_count", {16'h0, wb_count}, 32'd1);

    cyc(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
`ifdef REG_BANK_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h0;
`endif
    chk("same_edge_rd1", read_data_1, exp_byp);
    chk("same_edge_rd2", read_data_2, exp_byp);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd8);
    chk("after_edge_rd1", read_data_1, 32'hA5A5A5A5);
    chk("after_edge_rd2", read_data_2, 32'hDEADBEEF);

    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), 5'($urandom), $urandom,
          5'($urandom), 5'($urandom));
    end

    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 65535; i++) begin
      cyc(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom));
    end
    chk("count_ffff", {16'h0, wb_count}, 32'h0000FFFF);
    cyc(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom));
    chk("count_wrap", {16'h0, wb_count}, 32'h0);

    cyc(1'b1, 1'b1, 5'd29, 32'hFFFFFFFF, 5'd29, 5'd29);
    chk("reset_with_write_cnt", {16'h0, wb_count}, 32'h0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd0);
    chk("reset_with_write_sp", read_data_1, 32'h000000E3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_wb.md
# reg_bank_wb

Thirty-two-entry, 32-bit general-purpose register bank that consumes the write-back path of the multicycle CPU. It is the receiving end of the memory-to-register selector: it latches the selected write-back word into the addressed register, and it serves the two operand reads that feed the A/B operand registers. Register 0 is hardwired to zero. Register 29 resets to the stack-pointer seed 227 (0x000000E3).

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width
- SP_IDX, 29, index of the stack-pointer register
- SP_RESET, 32'h000000E3, reset value of register SP_IDX

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- reg_write  input  1  write enable for the write-back port
- write_reg  input  ADDR_W  destination register index
- write_data  input  DATA_W  write-back word from the memory-to-register selector
- read_reg_1  input  ADDR_W  source index, port A
- read_reg_2  input  ADDR_W  source index, port B
- read_data_1  output  DATA_W  registered read data, port A
- read_data_2  output  DATA_W  registered read data, port B
- wb_count  output  16  number of accepted register writes since reset; wraps

## Operation
- Write: on a rising edge with reg_write=1 and write_reg≠0, set reg[write_reg] = write_data.
- Write to index 0 is discarded. It does not increment wb_count.
- Read: on each rising edge, read_data_1 is loaded with reg[read_reg_1] and read_data_2 is loaded with reg[read_reg_2].
- Index 0 always reads 32'h0.
- wb_count increments by 1 on each accepted write. It wraps from 16'hFFFF to 16'h0000.
- Both ports may read the same index in the same cycle. Both outputs then return the same value.
- No read or write is ever rejected. No status flags.

## Timing
- Reset, checked at the clock edge with the highest priority:
  - every register is cleared to 0, except reg[SP_IDX], which is set to SP_RESET
  - read_data_1 = 0, read_data_2 = 0, wb_count = 0
  - a write presented in the same cycle as reset is dropped
- Write latency: write_data is visible in reg[] after 1 edge.
- Read latency: read_data_x reflects the index presented before the edge, 1 cycle later.
- Read-during-write to the same nonzero index in the same edge: the result depends on the configuration below.
- Reset asserted mid-sequence: all state is restored within that single edge. The first post-reset read of index 29 returns 0x000000E3.

## Configuration
- Macro: REG_BANK_BYPASS_EN.
- When defined:
  - a write and a read to the same nonzero index on the same edge forward write_data to the matching read_data_x output
  - read_data_x therefore equals the new value one cycle after the edge
- When undefined:
  - the same case returns the old register contents
  - the new value is seen on the following read
- Index 0 is never forwarded in either mode.

## Structure
- The shared CPU package holds:
  - REG_ZERO = 5'd0
  - REG_SP = 5'd29
  - SP_RESET_VAL = 32'h000000E3
  - the reg_idx_t typedef, 5 bits
- SP_RESET_VAL in the package is the same constant that the memory-to-register selector emits on its selector-0 input, so the two cannot drift apart.
- One sub-module, reg_wr_decoder:
  - turns reg_write plus write_reg into a 32-bit one-hot write-enable vector
  - bit 0 is forced low
- The read multiplexers and the bypass compare live in the top module.

## Test plan
- Reset, then read index 29 on port A and index 5 on port B → read_data_1=0x000000E3, read_data_2=0, wb_count=0.
- Write 0xDEADBEEF to index 8, then read index 8 on the next cycle → read_data_1=0xDEADBEEF one cycle later, wb_count=1.
- Write 0x12345678 to index 0, then read index 0 → read_data=0, wb_count unchanged.
- Same edge: write 0xA5A5A5A5 to index 3 and read index 3 on both ports:
  - with REG_BANK_BYPASS_EN → both outputs = 0xA5A5A5A5
  - without it → the previous value (0)
- Make 65536 accepted writes → wb_count returns to 0.
- Assert reset together with reg_write to index 29 carrying 0xFFFFFFFF → the write is dropped and index 29 reads 0x000000E3.
